// File: rtl/md_unit_if.sv
// Handshake/bus bundle between the E stage and the multiply/divide unit.
// The pipeline side (master) issues an op with its operands and the CP0
// request; the unit side (slave) reports start/busy and the HI/LO contents.
interface md_unit_if #(
  parameter int WIDTH = 32
);

  logic [2:0]       mdOp;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             req;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output mdOp, srcA, srcB, req,
    input  start, busy, hi, lo
  );

  modport slave (
    input  mdOp, srcA, srcB, req,
    output start, busy, hi, lo
  );

endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed from the operands present at start and parked in
// tmpHi/tmpLo; busy then runs for a fixed latency (MULT_CYCLES or DIV_CYCLES)
// and the parked result is committed to HI/LO on the final busy edge.
// MTHI/MTLO write HI/LO directly in one cycle whenever the unit is idle and no
// CP0 request is pending.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  mdBus
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdOpE;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } stateE;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdOpE              op;
  stateE             state;
  logic [CNT_W-1:0]  cnt;
  logic              busyReg;
  logic [WIDTH-1:0]  hiReg;
  logic [WIDTH-1:0]  loReg;
  logic [WIDTH-1:0]  tmpHi;
  logic [WIDTH-1:0]  tmpLo;
  logic              skipCommit;

  logic              isMulDiv;
  logic              isDiv;
  logic              startNow;
  logic              divZero;

  logic [2*WIDTH-1:0] prodS;
  logic [2*WIDTH-1:0] prodU;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic               negQ;
  logic               negR;
  logic [WIDTH-1:0]   resHi;
  logic [WIDTH-1:0]   resLo;

  assign op = mdOpE'(mdBus.mdOp);

  assign isMulDiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign isDiv    = (op == OP_DIV) || (op == OP_DIVU);
  assign divZero  = (mdBus.srcB == '0);
  assign startNow = isMulDiv && !busyReg && !mdBus.req;

  // Full-width products: sign- or zero-extend to 2*WIDTH so the low 2*WIDTH
  // bits of the product are exact for both signed and unsigned operands.
  assign prodS = {{WIDTH{mdBus.srcA[WIDTH-1]}}, mdBus.srcA} *
                 {{WIDTH{mdBus.srcB[WIDTH-1]}}, mdBus.srcB};
  assign prodU = {{WIDTH{1'b0}}, mdBus.srcA} * {{WIDTH{1'b0}}, mdBus.srcB};

  // Divide on magnitudes and fix the signs afterwards; most-negative / -1
  // falls out as quotient most-negative, remainder 0 with no special case.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    absA  = mdBus.srcA;
    absB  = mdBus.srcB;
    negQ  = 1'b0;
    negR  = 1'b0;
    resHi = '0;
    resLo = '0;
    if (op == OP_DIV) begin
      negQ = mdBus.srcA[WIDTH-1] ^ mdBus.srcB[WIDTH-1];
      negR = mdBus.srcA[WIDTH-1];
      if (mdBus.srcA[WIDTH-1]) absA = '0 - mdBus.srcA;
      if (mdBus.srcB[WIDTH-1]) absB = '0 - mdBus.srcB;
    end
    // A zero divisor is replaced by one to keep the divider defined; the
    // result is discarded at commit anyway.
    divisor = (absB == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : absB;
    quot    = absA / divisor;
    rem     = absA % divisor;
    if (negQ) quot = '0 - quot;
    if (negR) rem  = '0 - rem;
    case (op)
      OP_MULT:  {resHi, resLo} = prodS;
      OP_MULTU: {resHi, resLo} = prodU;
      OP_DIV,
      OP_DIVU: begin
        resHi = rem;
        resLo = quot;
      end
      default: begin
        resHi = '0;
        resLo = '0;
      end
    endcase
  end

  // Sequencer: latch result at start, count the latency, commit on the last busy edge.
  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: reset clears every register, including the parked result, so an
    // aborted op can never leak into HI/LO.
    if (reset) begin
      state      <= IDLE;
      busyReg    <= 1'b0;
      cnt        <= '0;
      hiReg      <= '0;
      loReg      <= '0;
      tmpHi      <= '0;
      tmpLo      <= '0;
      skipCommit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (startNow) begin
            tmpHi      <= resHi;
            tmpLo      <= resLo;
            skipCommit <= isDiv && divZero;
            cnt        <= isDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busyReg    <= 1'b1;
            state      <= BUSY;
          end else if (!mdBus.req) begin
            if (op == OP_MTHI) hiReg <= mdBus.srcA;
            if (op == OP_MTLO) loReg <= mdBus.srcA;
          end
        end
        BUSY: begin
          // New ops and MT* writes are ignored here; req does not cancel.
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            if (!skipCommit) begin
              hiReg <= tmpHi;
              loReg <= tmpLo;
            end
            busyReg <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          busyReg <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign mdBus.start = startNow;
  assign mdBus.busy  = busyReg;
  assign mdBus.hi    = hiReg;
  assign mdBus.lo    = loReg;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: one task per scenario, inline comparisons
// against hand-computed values. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_md_unit;

  localparam logic [2:0] NONE  = 3'd0;
  localparam logic [2:0] MULT  = 3'd1;
  localparam logic [2:0] MULTU = 3'd2;
  localparam logic [2:0] DIV   = 3'd3;
  localparam logic [2:0] DIVU  = 3'd4;
  localparam logic [2:0] MTHI  = 3'd5;
  localparam logic [2:0] MTLO  = 3'd6;

  logic clk;
  logic reset;
  int   checks;
  int   passes;

  md_unit_if #(.WIDTH(32)) mdBus ();

  md_unit #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mdBus(mdBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive an op at the current falling edge, record start, then advance one
  // cycle and replace the operands with garbage to prove they were sampled.
  task automatic issueOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic startSeen);
    mdBus.mdOp = op;
    mdBus.srcA = a;
    mdBus.srcB = b;
    #1 startSeen = mdBus.start;
    @(negedge clk);
    mdBus.mdOp = NONE;
    mdBus.srcA = $urandom;
    mdBus.srcB = $urandom;
  endtask

  // Count falling edges with busy high; returns at the first edge with busy low.
  task automatic waitIdle(output int busyCycles);
    busyCycles = 0;
    while (mdBus.busy === 1'b1 && busyCycles < 100) begin
      busyCycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    mdBus.mdOp = NONE;
    mdBus.srcA = '0;
    mdBus.srcB = '0;
    mdBus.req  = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mdBus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", mdBus.busy); else passes++;
    checks++; if (mdBus.hi !== 32'h0) $display("FAIL reset_hi: got %h expected 00000000", mdBus.hi); else passes++;
    checks++; if (mdBus.lo !== 32'h0) $display("FAIL reset_lo: got %h expected 00000000", mdBus.lo); else passes++;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (mdBus.start !== 1'b0) $display("FAIL reset_start: got %b expected 0", mdBus.start); else passes++;
  endtask

  task automatic test_mult;
    logic st;
    int   n;
    issueOp(MULT, 32'hFFFF_FFFE, 32'd3, st);
    waitIdle(n);
    checks++; if (st !== 1'b1) $display("FAIL mult_start: got %b expected 1", st); else passes++;
    checks++; if (n != 5) $display("FAIL mult_busy_cycles: got %0d expected 5", n); else passes++;
    checks++; if (mdBus.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h expected ffffffff", mdBus.hi); else passes++;
    checks++; if (mdBus.lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo: got %h expected fffffffa", mdBus.lo); else passes++;
  endtask

  task automatic test_multu;
    logic st;
    int   n;
    issueOp(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
    waitIdle(n);
    checks++; if (n != 5) $display("FAIL multu_busy_cycles: got %0d expected 5", n); else passes++;
    checks++; if (mdBus.hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h expected fffffffe", mdBus.hi); else passes++;
    checks++; if (mdBus.lo !== 32'h0000_0001) $display("FAIL multu_lo: got %h expected 00000001", mdBus.lo); else passes++;
  endtask

  task automatic test_div;
    logic st;
    int   n;
    issueOp(DIV, 32'hFFFF_FFF9, 32'd2, st);
    waitIdle(n);
    checks++; if (n != 10) $display("FAIL div_busy_cycles: got %0d expected 10", n); else passes++;
    checks++; if (mdBus.lo !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h expected fffffffd", mdBus.lo); else passes++;
    checks++; if (mdBus.hi !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h expected ffffffff", mdBus.hi); else passes++;
  endtask

  task automatic test_div_zero;
    logic st;
    int   n;
    // HI/LO still hold the previous DIV result: ffffffff / fffffffd.
    issueOp(DIVU, 32'd7, 32'd0, st);
    waitIdle(n);
    checks++; if (n != 10) $display("FAIL divzero_busy_cycles: got %0d expected 10", n); else passes++;
    checks++; if (mdBus.hi !== 32'hFFFF_FFFF) $display("FAIL divzero_hi: got %h expected ffffffff", mdBus.hi); else passes++;
    checks++; if (mdBus.lo !== 32'hFFFF_FFFD) $display("FAIL divzero_lo: got %h expected fffffffd", mdBus.lo); else passes++;
  endtask

  task automatic test_div_overflow;
    logic st;
    int   n;
    issueOp(DIV, 32'h8000_0000, 32'hFFFF_FFFF, st);
    waitIdle(n);
    checks++; if (mdBus.lo !== 32'h8000_0000) $display("FAIL divovf_lo: got %h expected 80000000", mdBus.lo); else passes++;
    checks++; if (mdBus.hi !== 32'h0) $display("FAIL divovf_hi: got %h expected 00000000", mdBus.hi); else passes++;
  endtask

  task automatic test_req;
    logic st;
    mdBus.req = 1'b1;
    issueOp(MULT, 32'd6, 32'd7, st);
    checks++; if (st !== 1'b0) $display("FAIL req_start: got %b expected 0", st); else passes++;
    checks++; if (mdBus.busy !== 1'b0) $display("FAIL req_busy: got %b expected 0", mdBus.busy); else passes++;
    // MTHI blocked by req as well.
    issueOp(MTHI, 32'hBEEF, 32'd0, st);
    checks++; if (mdBus.hi !== 32'h0) $display("FAIL req_mthi: got %h expected 00000000", mdBus.hi); else passes++;
    checks++; if (mdBus.lo !== 32'h8000_0000) $display("FAIL req_lo: got %h expected 80000000", mdBus.lo); else passes++;
    mdBus.req = 1'b0;
  endtask

  task automatic test_mt;
    logic st;
    issueOp(MTLO, 32'h1234, 32'd0, st);
    checks++; if (mdBus.lo !== 32'h1234) $display("FAIL mtlo_lo: got %h expected 00001234", mdBus.lo); else passes++;
    checks++; if (mdBus.busy !== 1'b0) $display("FAIL mtlo_busy: got %b expected 0", mdBus.busy); else passes++;
    issueOp(MTHI, 32'h5678, 32'd0, st);
    checks++; if (mdBus.hi !== 32'h5678) $display("FAIL mthi_hi: got %h expected 00005678", mdBus.hi); else passes++;
  endtask

  task automatic test_busy_ignore;
    logic st;
    logic stBusy;
    int   n;
    issueOp(MULT, 32'd2, 32'd3, st);
    n = 0;
    stBusy = 1'b0;
    while (mdBus.busy === 1'b1 && n < 100) begin
      n++;
      mdBus.mdOp = (n == 2) ? MTHI : (n == 3) ? DIVU : NONE;
      mdBus.srcA = 32'hDEAD;
      mdBus.srcB = 32'd2;
      #1 if (mdBus.start === 1'b1) stBusy = 1'b1;
      @(negedge clk);
    end
    mdBus.mdOp = NONE;
    checks++; if (stBusy !== 1'b0) $display("FAIL busy_start: got %b expected 0", stBusy); else passes++;
    checks++; if (n != 5) $display("FAIL busy_ignore_cycles: got %0d expected 5", n); else passes++;
    checks++; if (mdBus.hi !== 32'h0) $display("FAIL busy_ignore_hi: got %h expected 00000000", mdBus.hi); else passes++;
    checks++; if (mdBus.lo !== 32'd6) $display("FAIL busy_ignore_lo: got %h expected 00000006", mdBus.lo); else passes++;
    @(negedge clk);
    checks++; if (mdBus.busy !== 1'b0) $display("FAIL busy_ignore_after: got %b expected 0", mdBus.busy); else passes++;
  endtask

  task automatic test_reset_mid;
    logic st;
    int   n;
    issueOp(DIV, 32'd100, 32'd3, st);
    n = 1;
    while (n < 4 && mdBus.busy === 1'b1) begin
      n++;
      @(negedge clk);
    end
    checks++; if (mdBus.busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", mdBus.busy); else passes++;
    reset = 1'b1;
    #1;
    checks++; if (mdBus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", mdBus.busy); else passes++;
    checks++; if (mdBus.hi !== 32'h0) $display("FAIL rstmid_hi: got %h expected 00000000", mdBus.hi); else passes++;
    checks++; if (mdBus.lo !== 32'h0) $display("FAIL rstmid_lo: got %h expected 00000000", mdBus.lo); else passes++;
    @(negedge clk);
    reset = 1'b0;
    issueOp(MULT, 32'd6, 32'd7, st);
    waitIdle(n);
    checks++; if (n != 5) $display("FAIL rstmid_mult_cycles: got %0d expected 5", n); else passes++;
    checks++; if (mdBus.lo !== 32'd42) $display("FAIL rstmid_mult_lo: got %h expected 0000002a", mdBus.lo); else passes++;
    checks++; if (mdBus.hi !== 32'h0) $display("FAIL rstmid_mult_hi: got %h expected 00000000", mdBus.hi); else passes++;
  endtask

  task automatic test_back_to_back;
    logic st;
    int   n;
    issueOp(MULT, 32'd5, 32'hFFFF_FFFC, st);
    waitIdle(n);
    // This falling edge is the single idle cycle between the two windows.
    checks++; if (mdBus.hi !== 32'hFFFF_FFFF) $display("FAIL b2b_mult_hi: got %h expected ffffffff", mdBus.hi); else passes++;
    checks++; if (mdBus.lo !== 32'hFFFF_FFEC) $display("FAIL b2b_mult_lo: got %h expected ffffffec", mdBus.lo); else passes++;
    issueOp(DIV, 32'd100, 32'hFFFF_FFF9, st);
    checks++; if (st !== 1'b1) $display("FAIL b2b_div_start: got %b expected 1", st); else passes++;
    checks++; if (mdBus.busy !== 1'b1) $display("FAIL b2b_gap: got busy %b expected 1", mdBus.busy); else passes++;
    waitIdle(n);
    checks++; if (n != 10) $display("FAIL b2b_div_cycles: got %0d expected 10", n); else passes++;
    checks++; if (mdBus.lo !== 32'hFFFF_FFF2) $display("FAIL b2b_div_lo: got %h expected fffffff2", mdBus.lo); else passes++;
    checks++; if (mdBus.hi !== 32'd2) $display("FAIL b2b_div_hi: got %h expected 00000002", mdBus.hi); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_div_overflow();
    test_req();
    test_mt();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
